// File: rtl/store_pkg.sv
// Shared types and defaults for the STORE read-side logic.
// Holds the reader FSM encoding and the default slot width.
package store_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SINGLE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/store_reader_snapshot.sv
// slot_snapshot: SLOTS x DATA_W register bank, loaded in one shot.
// Ports: clk, reset_n, load, bank (flat slots), sel -> rd_data.
module slot_snapshot #(
  parameter int DATA_W = 8,
  parameter int SLOTS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load,
  input  logic [SLOTS*DATA_W-1:0] bank,
  input  logic [ADDR_W-1:0]       sel,
  output logic [DATA_W-1:0]       rd_data
);

  logic [DATA_W-1:0] mem [SLOTS];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < SLOTS; i++)
        mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < SLOTS; i++)
        mem[i] <= bank[i*DATA_W +: DATA_W];
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < SLOTS; i++)
      if (sel == ADDR_W'(i))
        rd_data = mem[i];
  end

endmodule

// File: rtl/store_reader.sv
// store_reader: single-read or snapshot scan of a STORE bank.
// Ports: clk, reset_n, bank, rd_req/rd_addr, scan_start, out_* handshake, busy.
module store_reader
  import store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SLOTS  = 4,
  parameter int ADDR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [SLOTS*DATA_W-1:0] bank,
  input  logic                    rd_req,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    scan_start,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_last,
  output logic                    busy
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SLOTS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic [DATA_W-1:0] snap_data;
  logic [DATA_W-1:0] live_data;
  logic              snap_load;
  logic              idx_end;

  assign snap_load = (state_q == ST_IDLE) && scan_start;
  assign idx_end   = (idx_q == LAST);

  slot_snapshot #(
    .DATA_W (DATA_W),
    .SLOTS  (SLOTS),
    .ADDR_W (ADDR_W)
  ) u_snap (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (snap_load),
    .bank    (bank),
    .sel     (idx_q),
    .rd_data (snap_data)
  );

  // Live bank mux for single reads; out-of-range reads as zero.
  always_comb begin
    live_data = '0;
    for (int i = 0; i < SLOTS; i++)
      if (rd_addr == ADDR_W'(i))
        live_data = bank[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (!reset_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (scan_start)
          state_d = ST_SCAN;
        else if (rd_req)
          state_d = ST_SINGLE;
      end
      ST_SINGLE: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
      ST_SCAN: begin
        if (out_ready && idx_end)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
      last_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (scan_start) begin
            idx_q <= '0;
          end else if (rd_req) begin
            data_q <= live_data;
            addr_q <= rd_addr;
            last_q <= 1'b1;
          end
        end
        ST_SINGLE: begin
          if (out_ready)
            last_q <= 1'b0;
        end
        ST_SCAN: begin
          if (out_ready)
            idx_q <= idx_end ? '0 : idx_q + 1'b1;
        end
        default: idx_q <= '0;
      endcase
    end
  end

  // A scan presents the snapshot entry at idx; a single read
  // presents the value captured on the request edge.
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = busy;
  assign out_data  = (state_q == ST_SCAN) ? snap_data : data_q;
  assign out_addr  = (state_q == ST_SCAN) ? idx_q : addr_q;
  assign out_last  = (state_q == ST_SCAN) ? idx_end : last_q;

endmodule

// File: tb/tb_store_reader.sv
// Testbench for store_reader: cycle vector table plus
// hand-written backpressure and mid-scan reset sequences.
module tb_store_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bank;
  logic        rd_req;
  logic [1:0]  rd_addr;
  logic        scan_start;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_addr;
  logic        out_last;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  store_reader #(.DATA_W(8), .SLOTS(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bank       (bank),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .scan_start (scan_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_addr   (out_addr),
    .out_last   (out_last),
    .busy       (busy)
  );

  typedef struct {
    logic        rst_n;
    logic [31:0] bank;
    logic        rd_req;
    logic [1:0]  rd_addr;
    logic        scan;
    logic        ready;
    logic        chkd;
    logic        valid;
    logic [7:0]  data;
    logic [1:0]  addr;
    logic        last;
    logic        busy;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst_n, input logic [31:0] b,
    input logic rq, input logic [1:0] ra,
    input logic sc, input logic rdy, input logic cd,
    input logic v, input logic [7:0] d,
    input logic [1:0] a, input logic l, input logic bz
  );
    vec_t t;
    t.rst_n = rst_n; t.bank = b; t.rd_req = rq;
    t.rd_addr = ra; t.scan = sc; t.ready = rdy;
    t.chkd = cd; t.valid = v; t.data = d;
    t.addr = a; t.last = l; t.busy = bz;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] b,
                       input logic rq, input logic [1:0] ra,
                       input logic sc, input logic rdy);
    reset_n = r; bank = b; rd_req = rq;
    rd_addr = ra; scan_start = sc; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_item(input string nm, input logic [7:0] d,
                          input logic [1:0] a, input logic l);
    chk({nm, " valid"}, 32'(out_valid), 32'd1);
    chk({nm, " data"}, 32'(out_data), 32'(d));
    chk({nm, " addr"}, 32'(out_addr), 32'(a));
    chk({nm, " last"}, 32'(out_last), 32'(l));
  endtask

  localparam logic [31:0] B1 = 32'h4433_2211;
  localparam logic [31:0] B1X = 32'h44FF_2211;
  localparam logic [31:0] B2 = 32'hD4C3_B2A1;
  localparam logic [31:0] BR = 32'h5A3C_96E1;

  initial begin
    int k;
    logic rdy;
    drive(1'b0, BR, 1'b1, 2'd2, 1'b0, 1'b0);

    // reset held with request pending
    add(0, BR, 1, 2, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    add(0, BR, 1, 2, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    // release, no request: nothing appears
    add(1, BR, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0);
    add(1, BR, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0);
    // single read of slot 2, held under backpressure
    add(1, B1, 1, 2, 0, 0, 1, 1, 8'h33, 2, 1, 1);
    add(1, B1X, 0, 0, 0, 0, 1, 1, 8'h33, 2, 1, 1);
    add(1, B1X, 0, 0, 0, 0, 1, 1, 8'h33, 2, 1, 1);
    add(1, B1X, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, B1X, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    // back-to-back scan
    add(1, B2, 0, 0, 1, 1, 1, 1, 8'hA1, 0, 0, 1);
    add(1, B2, 0, 0, 0, 1, 1, 1, 8'hB2, 1, 0, 1);
    add(1, B2, 0, 0, 0, 1, 1, 1, 8'hC3, 2, 0, 1);
    add(1, B2, 0, 0, 0, 1, 1, 1, 8'hD4, 3, 1, 1);
    add(1, B2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    // scan and read together, then requests while busy
    add(1, B2, 1, 1, 1, 1, 1, 1, 8'hA1, 0, 0, 1);
    add(1, B2, 1, 1, 1, 1, 1, 1, 8'hB2, 1, 0, 1);
    add(1, B2, 1, 0, 0, 1, 1, 1, 8'hC3, 2, 0, 1);
    add(1, B2, 0, 0, 1, 1, 1, 1, 8'hD4, 3, 1, 1);
    add(1, B2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    add(1, B2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);
    // out-of-range is impossible at SLOTS=4; slot 0 read
    add(1, B2, 1, 0, 0, 1, 1, 1, 8'hA1, 0, 1, 1);
    add(1, B2, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].rst_n, vq[i].bank, vq[i].rd_req,
            vq[i].rd_addr, vq[i].scan, vq[i].ready);
      step();
      chk($sformatf("v%0d valid", i), 32'(out_valid), 32'(vq[i].valid));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vq[i].busy));
      if (vq[i].chkd) begin
        chk($sformatf("v%0d data", i), 32'(out_data), 32'(vq[i].data));
        chk($sformatf("v%0d addr", i), 32'(out_addr), 32'(vq[i].addr));
        chk($sformatf("v%0d last", i), 32'(out_last), 32'(vq[i].last));
      end
    end

    // scan under alternating backpressure, bank cleared mid-scan
    drive(1'b1, B2, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    chk_item("bp start", 8'hA1, 2'd0, 1'b0);
    k = 0;
    for (int c = 0; c < 8; c++) begin
      rdy = (c % 2 == 0);
      drive(1'b1, (k >= 1) ? 32'h0 : B2, 1'b0, 2'd0, 1'b0, rdy);
      step();
      if (rdy && k < 4) k++;
      if (k < 4)
        chk_item($sformatf("bp c%0d", c), 8'hA1 + 8'(k) * 8'h11,
                 2'(k), k == 3);
      else
        chk($sformatf("bp c%0d done", c), 32'(out_valid), 32'd0);
    end
    chk("bp busy end", 32'(busy), 32'd0);

    // reset after two transfers aborts the scan
    drive(1'b1, B2, 1'b0, 2'd0, 1'b1, 1'b1);
    step();
    chk_item("rs s0", 8'hA1, 2'd0, 1'b0);
    drive(1'b1, B2, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    chk_item("rs s1", 8'hB2, 2'd1, 1'b0);
    step();
    chk_item("rs s2", 8'hC3, 2'd2, 1'b0);
    drive(1'b0, B2, 1'b0, 2'd0, 1'b0, 1'b1);
    step();
    chk("rs valid", 32'(out_valid), 32'd0);
    chk("rs busy", 32'(busy), 32'd0);
    drive(1'b1, B1, 1'b0, 2'd0, 1'b0, 1'b0);
    step();
    chk("rs idle", 32'(out_valid), 32'd0);
    drive(1'b1, B1, 1'b0, 2'd0, 1'b1, 1'b0);
    step();
    chk_item("rs fresh", 8'h11, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_reader.md
Name: store_reader

Overview:
- Read-side counterpart to the team's 8-bit STORE memory cells.
- A bank of SLOTS STORE-style cells drives its outputs into this block as one flattened bus.
- Supports two operations, both delivered to a consumer over a valid/ready output handshake:
  - single read of one addressed slot;
  - scan that streams every slot in address order.
- A scan reads from a snapshot taken at its start, so STORE writes during the scan cannot tear it.

Parameters:
- DATA_W, 8, width of one stored slot
- SLOTS, 4, number of STORE slots on the bank bus (>=2)
- ADDR_W, 2, slot index width; must satisfy 2**ADDR_W >= SLOTS

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset_n  input  1  synchronous active-low reset, sampled on clk rising edge
- bank  input  SLOTS*DATA_W  live STORE outputs; slot i at bits [i*DATA_W +: DATA_W]
- rd_req  input  1  single-read request; sampled only when busy=0
- rd_addr  input  ADDR_W  slot index for rd_req
- scan_start  input  1  start full scan; sampled only when busy=0
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  consumer accepts the current item
- out_data  output  DATA_W  read data
- out_addr  output  ADDR_W  slot index of out_data
- out_last  output  1  final item of the current operation
- busy  output  1  operation in progress; new requests ignored

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low on reset_n.
- Reset (reset_n=0 at a clk edge):
  - state=IDLE;
  - out_valid=0, out_data=0, out_addr=0, out_last=0, busy=0;
  - scan index=0; snapshot registers=0.
  - Reset mid-operation aborts it immediately. The in-flight item is dropped; no partial handshake.
- FSM states: IDLE, SINGLE, SCAN. busy=1 iff state != IDLE.
- Transfer occurs on a clk edge where out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, out_data/out_addr/out_last hold stable.
- IDLE, scan_start=1:
  - snapshot[i] <= bank slot i for all i; idx <= 0; state <= SCAN.
  - Next cycle: out_valid=1, out_data=snapshot[0], out_addr=0. Latency 1 cycle.
- IDLE, rd_req=1 (scan_start=0):
  - out_data <= bank[rd_addr] sampled that edge; out_addr <= rd_addr; out_last <= 1; out_valid <= 1; state <= SINGLE.
  - Latency 1 cycle.
  - If rd_addr >= SLOTS, out_data <= 0; everything else is unchanged.
- scan_start and rd_req in the same IDLE cycle: scan wins, rd_req is discarded.
- SINGLE: on transfer, out_valid <= 0, out_last <= 0, state <= IDLE.
- SCAN:
  - out_valid held 1; out_data=snapshot[idx]; out_addr=idx; out_last=(idx==SLOTS-1).
  - On transfer with idx<SLOTS-1: idx <= idx+1. With out_ready held high this gives one item per cycle, no bubbles.
  - On transfer with idx==SLOTS-1: out_valid <= 0, out_last <= 0, idx <= 0, state <= IDLE.
- rd_req/scan_start while busy=1: ignored, with no queuing.
- A new request may be accepted in the cycle after busy falls, giving one idle cycle between operations.
- Changes on bank during SCAN never affect scan output; changes during SINGLE after the capture edge do not either.
- out_data/out_addr need not be cleared when out_valid=0, except by reset.

Decomposition:
- Shared package store_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_SINGLE=2'd1, ST_SCAN=2'd2;
  - default DATA_W=8.
- One natural sub-module, slot_snapshot: SLOTS x DATA_W register bank with a load enable and an index-select read port.
- FSM, index counter and output registers live in store_reader.

Test Plan:
- Reset: hold reset_n=0 two cycles with random bank and rd_req=1 -> out_valid=0, out_data=8'h00, busy=0 throughout; no output on release until a request.
- Single read: bank={8'h44,8'h33,8'h22,8'h11}, rd_req=1, rd_addr=2 -> next cycle out_valid=1, out_data=8'h33, out_addr=2, out_last=1. With out_ready=0 for 3 cycles the values hold; change bank slot 2 to 8'hFF in that window -> still 8'h33. Then out_ready=1 -> busy=0 the next cycle.
- Back-to-back scan: bank={8'hD4,8'hC3,8'hB2,8'hA1}, scan_start=1, out_ready=1 -> four consecutive cycles out_data 8'hA1,8'hB2,8'hC3,8'hD4, out_addr 0..3, out_last=1 only on 8'hD4, then out_valid=0.
- Scan snapshot with backpressure: start scan on bank above, toggle out_ready 1/0 each cycle, overwrite all slots with 8'h00 after the first transfer -> still 8'hA1..8'hD4 in order, each held while out_ready=0.
- Simultaneous and busy requests: scan_start=1 and rd_req=1 (rd_addr=1) same cycle -> full scan only. During the scan, pulse rd_req and scan_start -> ignored, exactly 4 items delivered.
- Reset mid-scan: assert reset_n=0 after 2 transfers -> next edge out_valid=0, busy=0. A fresh scan after release restarts at out_addr=0.
